// File: rtl/board_io_pkg.sv
// board_io_pkg: shared constants for the board I/O peripheral.
//   - byte offsets of the memory-mapped registers
//   - HEX_CTRL field positions
//   - seven-segment lookup (active-low, bit0=a .. bit6=g) and blank pattern
package board_io_pkg;

    localparam logic [4:0] OFF_LED      = 5'h00;
    localparam logic [4:0] OFF_HEX_DATA = 5'h04;
    localparam logic [4:0] OFF_HEX_CTRL = 5'h08;
    localparam logic [4:0] OFF_SW       = 5'h0C;
    localparam logic [4:0] OFF_KEY      = 5'h10;
    localparam logic [4:0] OFF_KEY_EVT  = 5'h14;
    localparam logic [4:0] OFF_IRQ_EN   = 5'h18;

    localparam int CTRL_EN_LSB    = 0;
    localparam int CTRL_BLINK_LSB = 8;
    localparam int CTRL_BLANK_BIT = 16;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry 15 first, entry 0 last.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low seven-segment pattern.
//   digit  in  4  nibble to display
//   seg    out 7  segments, bit0=a .. bit6=g, active-low
module seg7_decode
    import board_io_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[digit];

endmodule

// File: rtl/board_io_mmio.sv
// board_io_mmio: memory-mapped LED / seven-segment / switch / key peripheral.
//   CLOCK_50, RESET_N        clock, async active-low reset
//   req_valid/we/addr/wdata  bus request (always accepted, req_ready=1)
//   rsp_valid/rsp_rdata      registered response, one cycle after request
//   SW, KEY                  raw asynchronous inputs (KEY active-low)
//   LEDR, HEX                registered LED / segment drive (HEX active-low)
//   irq                      level interrupt = |(KEY_EVT & IRQ_EN), registered
module board_io_mmio
    import board_io_pkg::*;
#(
    parameter int N_LED        = 10,
    parameter int N_SW         = 10,
    parameter int N_KEY        = 4,
    parameter int N_HEX        = 6,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [4:0]         req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    input  logic [N_SW-1:0]    SW,
    input  logic [N_KEY-1:0]   KEY,
    output logic [N_LED-1:0]   LEDR,
    output logic [7*N_HEX-1:0] HEX,
    output logic               irq
);

    localparam int TW = $clog2(DEBOUNCE_CYC);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [TW-1:0] TICK_MAX  = TW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [N_SW-1:0]    sw_s1, sw_s2, sw_prev, sw_db, sw_db_nxt, sw_agree;
    logic [N_KEY-1:0]   key_s1, key_s2, key_prev, key_db, key_db_nxt, key_agree;
    logic [N_KEY-1:0]   key_rise, key_evt, evt_clr, irq_en;
    logic [TW-1:0]      tick_cnt;
    logic               tick;
    logic [BW-1:0]      blink_cnt;
    logic               blink_wrap, phase, phase_nxt;
    logic [N_LED-1:0]   led;
    logic [4*N_HEX-1:0] hex_data, hex_data_nxt;
    logic [N_HEX-1:0]   dig_en, dig_en_nxt, blink_mask, blink_mask_nxt;
    logic               blank, blank_nxt;
    logic [N_HEX-1:0][6:0] seg_dec;
    logic [7*N_HEX-1:0] hex_nxt, hex_q;
    logic               wr;
    logic [4:0]         off;
    logic [31:0]        rdata_nxt;
    logic               unused_bits;

    assign req_ready   = 1'b1;
    assign wr          = req_valid & req_we;
    assign off         = {req_addr[4:2], 2'b00};
    assign unused_bits = ^{req_addr[1:0], req_wdata};

    // Debounce: a bit follows its tick sample only when two consecutive
    // samples agree. Keys are inverted ahead of the synchroniser so that
    // the all-zero reset state means "not pressed".
    assign tick       = (tick_cnt == TICK_MAX);
    assign sw_agree   = ~(sw_s2 ^ sw_prev);
    assign key_agree  = ~(key_s2 ^ key_prev);
    assign sw_db_nxt  = tick ? ((sw_s2 & sw_agree) | (sw_db & ~sw_agree)) : sw_db;
    assign key_db_nxt = tick ? ((key_s2 & key_agree) | (key_db & ~key_agree)) : key_db;
    assign key_rise   = key_db_nxt & ~key_db;

    assign blink_wrap = (blink_cnt == BLINK_MAX);
    assign phase_nxt  = phase ^ blink_wrap;
    assign evt_clr    = (wr && off == OFF_KEY_EVT) ? req_wdata[N_KEY-1:0] : '0;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sw_s1 <= '0; sw_s2 <= '0; sw_prev <= '0; sw_db <= '0;
            key_s1 <= '0; key_s2 <= '0; key_prev <= '0; key_db <= '0;
            tick_cnt <= '0;
            blink_cnt <= '0;
            phase <= 1'b0;
        end else begin
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
            key_s1 <= ~KEY;
            key_s2 <= key_s1;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
                sw_prev  <= sw_s2;
                key_prev <= key_s2;
            end
            sw_db  <= sw_db_nxt;
            key_db <= key_db_nxt;
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
            phase <= phase_nxt;
        end
    end

    // Display registers are looked at through their next values so the
    // registered HEX output lands in the same cycle as the write response.
    always_comb begin
        hex_data_nxt   = hex_data;
        dig_en_nxt     = dig_en;
        blink_mask_nxt = blink_mask;
        blank_nxt      = blank;
        if (wr && off == OFF_HEX_DATA)
            hex_data_nxt = req_wdata[4*N_HEX-1:0];
        if (wr && off == OFF_HEX_CTRL) begin
            dig_en_nxt     = req_wdata[CTRL_EN_LSB +: N_HEX];
            blink_mask_nxt = req_wdata[CTRL_BLINK_LSB +: N_HEX];
            blank_nxt      = req_wdata[CTRL_BLANK_BIT];
        end
    end

    for (genvar i = 0; i < N_HEX; i++) begin : g_dig
        seg7_decode u_dec (
            .digit (hex_data_nxt[4*i +: 4]),
            .seg   (seg_dec[i])
        );
        assign hex_nxt[7*i +: 7] =
            (dig_en_nxt[i] && !blank_nxt && !(blink_mask_nxt[i] && phase_nxt))
            ? seg_dec[i] : SEG_BLANK;
    end

    always_comb begin
        rdata_nxt = '0;
        if (req_valid && !req_we) begin
            case (off)
                OFF_LED:      rdata_nxt[N_LED-1:0]   = led;
                OFF_HEX_DATA: rdata_nxt[4*N_HEX-1:0] = hex_data;
                OFF_HEX_CTRL: begin
                    rdata_nxt[CTRL_EN_LSB +: N_HEX]    = dig_en;
                    rdata_nxt[CTRL_BLINK_LSB +: N_HEX] = blink_mask;
                    rdata_nxt[CTRL_BLANK_BIT]          = blank;
                end
                OFF_SW:       rdata_nxt[N_SW-1:0]  = sw_db;
                OFF_KEY:      rdata_nxt[N_KEY-1:0] = key_db;
                OFF_KEY_EVT:  rdata_nxt[N_KEY-1:0] = key_evt;
                OFF_IRQ_EN:   rdata_nxt[N_KEY-1:0] = irq_en;
                default:      rdata_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            led        <= '0;
            irq_en     <= '0;
            hex_data   <= '0;
            dig_en     <= '0;
            blink_mask <= '0;
            blank      <= 1'b0;
            hex_q      <= {N_HEX{SEG_BLANK}};
            key_evt    <= '0;
            irq        <= 1'b0;
        end else begin
            rsp_valid <= req_valid;
            rsp_rdata <= rdata_nxt;
            if (wr && off == OFF_LED)    led    <= req_wdata[N_LED-1:0];
            if (wr && off == OFF_IRQ_EN) irq_en <= req_wdata[N_KEY-1:0];
            hex_data   <= hex_data_nxt;
            dig_en     <= dig_en_nxt;
            blink_mask <= blink_mask_nxt;
            blank      <= blank_nxt;
            hex_q      <= hex_nxt;
            // Set is OR'd in after the clear so a same-cycle event survives.
            key_evt    <= (key_evt & ~evt_clr) | key_rise;
            irq        <= |(key_evt & irq_en);
        end
    end

    assign LEDR = led;
    assign HEX  = hex_q;

endmodule

// File: tb/tb_board_io_mmio.sv
module tb_board_io_mmio;

    localparam int N_LED = 10, N_SW = 10, N_KEY = 4, N_HEX = 6;

    logic               CLOCK_50 = 1'b0;
    logic               RESET_N  = 1'b0;
    logic               req_valid = 1'b0, req_we = 1'b0;
    logic               req_ready;
    logic [4:0]         req_addr  = '0;
    logic [31:0]        req_wdata = '0;
    logic               rsp_valid;
    logic [31:0]        rsp_rdata;
    logic [N_SW-1:0]    SW  = '0;
    logic [N_KEY-1:0]   KEY = '1;
    logic [N_LED-1:0]   LEDR;
    logic [7*N_HEX-1:0] HEX;
    logic               irq;

    int checks = 0, failures = 0;
    int cyc;
    logic [31:0] r;

    localparam logic [41:0] HEX_ALL_BLANK = {6{7'h7F}};
    localparam logic [41:0] HEX_FEDCBA = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08};

    board_io_mmio #(
        .N_LED(N_LED), .N_SW(N_SW), .N_KEY(N_KEY), .N_HEX(N_HEX),
        .DEBOUNCE_CYC(4), .BLINK_DIV(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .SW(SW), .KEY(KEY), .LEDR(LEDR), .HEX(HEX), .irq(irq)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Clock edges seen out of reset; tick and blink phase follow from it.
    always @(posedge CLOCK_50 or negedge RESET_N)
        if (!RESET_N) cyc <= 0; else cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Drive one request; returns at #1 after the accepting edge.
    task automatic bus(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        step(1);
        req_valid = 1'b0; req_we = 1'b0;
        chk("rsp_valid", {63'b0, rsp_valid}, 64'd1);
        rd = rsp_rdata;
    endtask

    task automatic idle_chk();
        step(1);
        chk("rsp_pulse_end", {63'b0, rsp_valid}, 64'd0);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        bus(1'b1, addr, wd, rd);
        chk("wr_rdata", {32'b0, rd}, 64'd0);
        idle_chk();
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus(1'b0, addr, 32'h0, rd);
        chk(tag, {32'b0, rd}, {32'b0, exp});
        idle_chk();
    endtask

    initial begin
        // Reset
        step(3);
        chk("rst_hex", {22'b0, HEX}, {22'b0, HEX_ALL_BLANK});
        chk("rst_ledr", {54'b0, LEDR}, 64'd0);
        chk("rst_irq", {63'b0, irq}, 64'd0);
        chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'b0, rsp_rdata}, 64'd0);
        RESET_N = 1'b1;
        for (int a = 0; a < 8; a++) rd_chk("rst_read", 5'(a * 4), 32'h0);

        // Unmapped write is ignored
        wr(5'h1C, 32'hFFFF_FFFF);
        rd_chk("unmapped_read", 5'h1C, 32'h0);
        chk("unmapped_ledr", {54'b0, LEDR}, 64'd0);

        // LED / HEX writes, outputs coincident with the response
        bus(1'b1, 5'h00, 32'h3FF, r);
        chk("ledr_coincident", {54'b0, LEDR}, 64'h3FF);
        idle_chk();
        wr(5'h04, 32'h00FE_DCBA);
        chk("hex_disabled", {22'b0, HEX}, {22'b0, HEX_ALL_BLANK});
        bus(1'b1, 5'h08, 32'h3F, r);
        chk("hex_coincident", {22'b0, HEX}, {22'b0, HEX_FEDCBA});
        idle_chk();
        rd_chk("rd_hex_data", 5'h04, 32'h00FE_DCBA);
        rd_chk("rd_hex_ctrl", 5'h08, 32'h0000_003F);
        wr(5'h00, 32'hFFFF_FFFF);
        rd_chk("led_width", 5'h00, 32'h0000_03FF);

        // Blink on digit 0 only
        wr(5'h08, 32'h0000_013F);
        for (int k = 0; k < 20; k++) begin
            chk("blink_d0", {57'b0, HEX[6:0]},
                ((cyc / 8) % 2 == 1) ? 64'h7F : 64'h08);
            chk("blink_steady", {29'b0, HEX[41:7]}, {29'b0, HEX_FEDCBA[41:7]});
            step(1);
        end
        // Global blank
        wr(5'h08, 32'h0001_003F);
        chk("blank_hex", {22'b0, HEX}, {22'b0, HEX_ALL_BLANK});
        rd_chk("rd_blank_ctrl", 5'h08, 32'h0001_003F);

        // Switch debounce
        SW = 10'h155;
        rd_chk("sw_not_yet", 5'h0C, 32'h0);
        step(10);
        rd_chk("sw_stable", 5'h0C, 32'h155);
        SW = 10'h154;
        step(2);
        SW = 10'h155;
        step(12);
        rd_chk("sw_glitch", 5'h0C, 32'h155);

        // Key event and interrupt
        wr(5'h18, 32'h2);
        rd_chk("rd_irq_en", 5'h18, 32'h2);
        KEY = 4'b1101;
        step(12);
        rd_chk("key_state", 5'h10, 32'h2);
        rd_chk("key_evt", 5'h14, 32'h2);
        chk("irq_set", {63'b0, irq}, 64'd1);
        KEY = 4'b1111;
        step(12);
        rd_chk("key_released", 5'h10, 32'h0);
        rd_chk("key_evt_sticky", 5'h14, 32'h2);
        chk("irq_sticky", {63'b0, irq}, 64'd1);
        bus(1'b1, 5'h14, 32'h2, r);
        chk("irq_lag", {63'b0, irq}, 64'd1);
        idle_chk();
        chk("irq_cleared", {63'b0, irq}, 64'd0);
        rd_chk("key_evt_clr", 5'h14, 32'h0);

        // Clear and new KEY[3] event in the same cycle: set wins.
        // From a tick-aligned press, the second agreeing tick is 8 edges later.
        for (int k = 0; k < 4 && (cyc % 4) != 0; k++) step(1);
        KEY = 4'b0111;
        step(7);
        bus(1'b1, 5'h14, 32'h8, r);
        idle_chk();
        rd_chk("w1c_collision", 5'h14, 32'h8);
        chk("irq_masked", {63'b0, irq}, 64'd0);
        rd_chk("key3_state", 5'h10, 32'h8);

        // Reset in the middle of a pending read
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h14;
        #2 RESET_N = 1'b0;
        #1;
        chk("midrst_ledr", {54'b0, LEDR}, 64'd0);
        chk("midrst_hex", {22'b0, HEX}, {22'b0, HEX_ALL_BLANK});
        step(1);
        req_valid = 1'b0;
        chk("midrst_rsp", {63'b0, rsp_valid}, 64'd0);
        chk("midrst_irq", {63'b0, irq}, 64'd0);
        RESET_N = 1'b1;
        rd_chk("midrst_evt", 5'h14, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
